// File: rtl/stream_demux_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stream_demux_if                                                 |
// | Brief    : Bundle of the input stream and the two output streams of        |
// |            stream_demux. The slave modport is the demux view.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface stream_demux_if #(
    parameter int WIDTH = 8
);
    logic             sel;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_a_valid;
    logic [WIDTH-1:0] out_a_data;
    logic             out_a_ready;
    logic             out_b_valid;
    logic [WIDTH-1:0] out_b_data;
    logic             out_b_ready;

    modport master (
        output sel, in_valid, in_data, out_a_ready, out_b_ready,
        input  in_ready, out_a_valid, out_a_data, out_b_valid, out_b_data
    );

    modport slave (
        input  sel, in_valid, in_data, out_a_ready, out_b_ready,
        output in_ready, out_a_valid, out_a_data, out_b_valid, out_b_data
    );
endinterface
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stream_demux                                                    |
// | Brief    : 1-to-2 valid/ready stream demultiplexer with a one-entry        |
// |            holding register per output. Optional transfer counters are     |
// |            enabled by defining STREAM_DEMUX_CNT_EN.                        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module stream_demux #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    stream_demux_if.slave bus
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [7:0]    cnt_a,
    output logic [7:0]    cnt_b
`endif
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_a_q, state_a_d;
    logic [0:0]       state_b_q, state_b_d;
    logic [WIDTH-1:0] data_a_q, data_a_d;
    logic [WIDTH-1:0] data_b_q, data_b_d;
    logic             in_ready;
    logic             in_fire;
    logic             load_a, load_b;
    logic             pop_a, pop_b;

    // Ready looks only at the register chosen by sel, so a stalled
    // neighbour never blocks traffic to the other output.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (bus.sel) begin
                in_ready = (state_b_q == ST_EMPTY) || bus.out_b_ready;
            end else begin
                in_ready = (state_a_q == ST_EMPTY) || bus.out_a_ready;
            end
        end
    end

    assign in_fire = bus.in_valid & in_ready;
    assign load_a  = in_fire & ~bus.sel;
    assign load_b  = in_fire &  bus.sel;
    assign pop_a   = (state_a_q == ST_FULL) & bus.out_a_ready;
    assign pop_b   = (state_b_q == ST_FULL) & bus.out_b_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_a_q <= ST_EMPTY;
            state_b_q <= ST_EMPTY;
            data_a_q  <= '0;
            data_b_q  <= '0;
        end else begin
            state_a_q <= state_a_d;
            state_b_q <= state_b_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
        end
    end

    always_comb begin
        state_a_d = state_a_q;
        state_b_d = state_b_q;
        data_a_d  = load_a ? bus.in_data : data_a_q;
        data_b_d  = load_b ? bus.in_data : data_b_q;

        case (state_a_q)
            ST_EMPTY: if (load_a)           state_a_d = ST_FULL;
            ST_FULL:  if (pop_a && !load_a) state_a_d = ST_EMPTY;
            default:                        state_a_d = ST_EMPTY;
        endcase

        case (state_b_q)
            ST_EMPTY: if (load_b)           state_b_d = ST_FULL;
            ST_FULL:  if (pop_b && !load_b) state_b_d = ST_EMPTY;
            default:                        state_b_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        bus.in_ready    = in_ready;
        bus.out_a_valid = (state_a_q == ST_FULL);
        bus.out_a_data  = data_a_q;
        bus.out_b_valid = (state_b_q == ST_FULL);
        bus.out_b_data  = data_b_q;
    end

`ifdef STREAM_DEMUX_CNT_EN
    logic [7:0] cnt_a_q, cnt_a_d;
    logic [7:0] cnt_b_q, cnt_b_d;

    // 8-bit adders wrap 255 -> 0 on their own.
    always_comb begin
        cnt_a_d = cnt_a_q + {7'd0, pop_a};
        cnt_b_d = cnt_b_q + {7'd0, pop_b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_q <= 8'd0;
            cnt_b_q <= 8'd0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stream_demux                                                 |
// | Brief    : Self-checking bench for stream_demux against a queue model.     |
// |            Counter checks are active when STREAM_DEMUX_CNT_EN is defined.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_stream_demux;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    stream_demux_if #(.WIDTH(WIDTH)) bus ();

`ifdef STREAM_DEMUX_CNT_EN
    logic [7:0] cnt_a, cnt_b;
    stream_demux #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus), .cnt_a(cnt_a), .cnt_b(cnt_b));
`else
    stream_demux #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    // Reference: each output is a queue of at most one accepted word.
    logic [WIDTH-1:0] q_a[$];
    logic [WIDTH-1:0] q_b[$];
    int               n_a = 0;
    int               n_b = 0;
    logic             m_acc;

    function automatic logic exp_ready();
        if (rst) return 1'b0;
        if (bus.sel) return (q_b.size() == 0) || bus.out_b_ready;
        return (q_a.size() == 0) || bus.out_a_ready;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q_a.delete();
            q_b.delete();
            n_a = 0;
            n_b = 0;
        end else begin
            m_acc = bus.in_valid && exp_ready();
            if (q_a.size() != 0 && bus.out_a_ready) begin void'(q_a.pop_front()); n_a++; end
            if (q_b.size() != 0 && bus.out_b_ready) begin void'(q_b.pop_front()); n_b++; end
            if (m_acc) begin
                if (bus.sel) q_b.push_back(bus.in_data);
                else         q_a.push_back(bus.in_data);
            end
        end
    end

    task automatic cycle(input logic v, input logic s, input logic [WIDTH-1:0] d,
                         input logic ra, input logic rb);
        @(negedge clk);
        bus.in_valid    = v;
        bus.sel         = s;
        bus.in_data     = d;
        bus.out_a_ready = ra;
        bus.out_b_ready = rb;
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 8'h5A, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        n_checks++; if (bus.out_a_valid !== 1'b0 || bus.out_b_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got a=%b b=%b expected 0 0", bus.out_a_valid, bus.out_b_valid); end
        n_checks++; if (bus.out_a_data !== 8'h00 || bus.out_b_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got a=%h b=%h expected 00 00", bus.out_a_data, bus.out_b_data); end
`ifdef STREAM_DEMUX_CNT_EN
        n_checks++; if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin n_errors++; $display("FAIL reset_cnt: got a=%0d b=%0d expected 0 0", cnt_a, cnt_b); end
`endif
        rst = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_routing();
        cycle(1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL route_ready: got %b expected 1", bus.in_ready); end
        cycle(1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        n_checks++; if (bus.out_a_valid !== 1'b1 || bus.out_a_data !== 8'h11) begin n_errors++; $display("FAIL route_a: got v=%b d=%h expected 1 11", bus.out_a_valid, bus.out_a_data); end
        n_checks++; if (bus.out_b_valid !== 1'b0) begin n_errors++; $display("FAIL route_b_early: got %b expected 0", bus.out_b_valid); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++; if (bus.out_a_valid !== 1'b0) begin n_errors++; $display("FAIL route_a_once: got %b expected 0", bus.out_a_valid); end
        n_checks++; if (bus.out_b_valid !== 1'b1 || bus.out_b_data !== 8'h22) begin n_errors++; $display("FAIL route_b: got v=%b d=%h expected 1 22", bus.out_b_valid, bus.out_b_data); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++; if (bus.out_b_valid !== 1'b0) begin n_errors++; $display("FAIL route_b_once: got %b expected 0", bus.out_b_valid); end
    endtask

    task automatic test_stall();
        cycle(1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b0, 8'h44, 1'b0, 1'b1);
            n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_ready: got %b expected 0", bus.in_ready); end
            n_checks++; if (bus.out_a_valid !== 1'b1 || bus.out_a_data !== 8'h33) begin n_errors++; $display("FAIL stall_hold: got v=%b d=%h expected 1 33", bus.out_a_valid, bus.out_a_data); end
        end
        cycle(1'b1, 1'b0, 8'h44, 1'b1, 1'b1);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reload_ready: got %b expected 1", bus.in_ready); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++; if (bus.out_a_valid !== 1'b1 || bus.out_a_data !== 8'h44) begin n_errors++; $display("FAIL reload_data: got v=%b d=%h expected 1 44", bus.out_a_valid, bus.out_a_data); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++; if (bus.out_a_valid !== 1'b0) begin n_errors++; $display("FAIL reload_drain: got %b expected 0", bus.out_a_valid); end
    endtask

    task automatic test_independence();
        cycle(1'b1, 1'b0, 8'h66, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL indep_ready: got %b expected 1", bus.in_ready); end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++; if (bus.out_b_valid !== 1'b1 || bus.out_b_data !== 8'h55) begin n_errors++; $display("FAIL indep_b: got v=%b d=%h expected 1 55", bus.out_b_valid, bus.out_b_data); end
        n_checks++; if (bus.out_a_valid !== 1'b1 || bus.out_a_data !== 8'h66) begin n_errors++; $display("FAIL indep_a: got v=%b d=%h expected 1 66", bus.out_a_valid, bus.out_a_data); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_sel_change();
        cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h88, 1'b0, 1'b0);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL selchg_blocked: got %b expected 0", bus.in_ready); end
        cycle(1'b1, 1'b1, 8'h88, 1'b0, 1'b0);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL selchg_ready: got %b expected 1", bus.in_ready); end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (bus.out_b_valid !== 1'b1 || bus.out_b_data !== 8'h88) begin n_errors++; $display("FAIL selchg_b: got v=%b d=%h expected 1 88", bus.out_b_valid, bus.out_b_data); end
        n_checks++; if (bus.out_a_valid !== 1'b1 || bus.out_a_data !== 8'h77) begin n_errors++; $display("FAIL selchg_a: got v=%b d=%h expected 1 77", bus.out_a_valid, bus.out_a_data); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (bus.out_a_valid !== 1'b1 || bus.out_b_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_full: got a=%b b=%b expected 1 1", bus.out_a_valid, bus.out_b_valid); end
        rst = 1'b1;
        cycle(1'b1, 1'b0, 8'hBB, 1'b1, 1'b1);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL rstmid_ready: got %b expected 0", bus.in_ready); end
        n_checks++; if (bus.out_a_valid !== 1'b0 || bus.out_b_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid: got a=%b b=%b expected 0 0", bus.out_a_valid, bus.out_b_valid); end
        n_checks++; if (bus.out_a_data !== 8'h00 || bus.out_b_data !== 8'h00) begin n_errors++; $display("FAIL rstmid_data: got a=%h b=%h expected 00 00", bus.out_a_data, bus.out_b_data); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            n_checks++; if (bus.out_a_valid !== 1'b0 || bus.out_b_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_discard: got a=%b b=%b expected 0 0", bus.out_a_valid, bus.out_b_valid); end
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
            n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, bus.in_ready); end
            if (i > 0) begin
                n_checks++; if (bus.out_a_valid !== 1'b1 || bus.out_a_data !== 8'(i - 1)) begin n_errors++; $display("FAIL b2b_data[%0d]: got v=%b d=%h expected 1 %h", i, bus.out_a_valid, bus.out_a_data, 8'(i - 1)); end
            end
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (bus.out_a_valid !== 1'b1 || bus.out_a_data !== 8'h2B) begin n_errors++; $display("FAIL b2b_last: got v=%b d=%h expected 1 2b", bus.out_a_valid, bus.out_a_data); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (bus.out_a_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain: got %b expected 0", bus.out_a_valid); end
`ifdef STREAM_DEMUX_CNT_EN
        n_checks++; if (cnt_a !== 8'd44 || cnt_b !== 8'd0) begin n_errors++; $display("FAIL b2b_cnt: got a=%0d b=%0d expected 44 0", cnt_a, cnt_b); end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), WIDTH'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
            n_checks++; if (bus.in_ready !== exp_ready()) begin n_errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, bus.in_ready, exp_ready()); end
            n_checks++; if (bus.out_a_valid !== (q_a.size() != 0)) begin n_errors++; $display("FAIL rnd_a_valid[%0d]: got %b expected %b", i, bus.out_a_valid, q_a.size() != 0); end
            n_checks++; if (bus.out_b_valid !== (q_b.size() != 0)) begin n_errors++; $display("FAIL rnd_b_valid[%0d]: got %b expected %b", i, bus.out_b_valid, q_b.size() != 0); end
            if (q_a.size() != 0) begin
                n_checks++; if (bus.out_a_data !== q_a[0]) begin n_errors++; $display("FAIL rnd_a_data[%0d]: got %h expected %h", i, bus.out_a_data, q_a[0]); end
            end
            if (q_b.size() != 0) begin
                n_checks++; if (bus.out_b_data !== q_b[0]) begin n_errors++; $display("FAIL rnd_b_data[%0d]: got %h expected %h", i, bus.out_b_data, q_b[0]); end
            end
`ifdef STREAM_DEMUX_CNT_EN
            n_checks++; if (cnt_a !== 8'(n_a) || cnt_b !== 8'(n_b)) begin n_errors++; $display("FAIL rnd_cnt[%0d]: got a=%0d b=%0d expected %0d %0d", i, cnt_a, cnt_b, 8'(n_a), 8'(n_b)); end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.sel         = 1'b0;
        bus.in_data     = '0;
        bus.out_a_ready = 1'b0;
        bus.out_b_ready = 1'b0;
        test_reset();
        test_routing();
        test_stall();
        test_independence();
        test_sel_change();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port sel, input, 1 bit: destination of the current input word (0 = port a, 1 = port b).
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input word is offered.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the input word.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-008 The block SHALL have ports out_a_valid (output, 1), out_a_data (output, WIDTH) and out_a_ready (input, 1): output stream a.
REQ-009 The block SHALL have ports out_b_valid (output, 1), out_b_data (output, WIDTH) and out_b_ready (input, 1): output stream b.

Function
REQ-010 Input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; output transfer x SHALL occur where out_x_valid=1 and out_x_ready=1.
REQ-011 Each output SHALL own a one-entry holding register with states EMPTY (out_x_valid=0) and FULL (out_x_valid=1).
REQ-012 The transitions SHALL be: EMPTY->FULL on an input transfer with sel selecting x; FULL->EMPTY on an output transfer with no new input to x; FULL->FULL (reload) on a simultaneous output transfer and input transfer to x.
REQ-013 in_ready SHALL be combinational: 1 when the register selected by sel is EMPTY or is FULL with its out_x_ready=1; otherwise 0.
REQ-014 in_ready SHALL NOT depend on the state or ready of the non-selected output.
REQ-015 The latency SHALL be one cycle: a word accepted at edge N appears on out_x_data with out_x_valid=1 after edge N.
REQ-016 out_x_data SHALL be held stable while out_x_valid=1 and out_x_ready=0.
REQ-017 sel and in_data SHALL be sampled only at an input transfer; sel changes while in_valid=1 and in_ready=0 SHALL be permitted, with in_ready following the new sel.
REQ-018 Both outputs SHALL operate independently: a stalled output SHALL NOT block words routed to the other output.
REQ-019 Words routed to the same output SHALL leave in acceptance order; no word SHALL be dropped or duplicated.
REQ-020 The data path SHALL have no arithmetic; out_x_data SHALL equal the captured in_data bit-for-bit.

Reset
REQ-021 While rst=1 at a clock edge, both registers SHALL go to EMPTY, out_a_valid and out_b_valid SHALL be 0, out_a_data and out_b_data SHALL be 0, and any counters SHALL be 0.
REQ-022 While rst=1, in_ready SHALL be 0 and no transfer SHALL occur.
REQ-023 A reset asserted mid-operation SHALL discard held words without emitting them.
REQ-024 Operation SHALL resume on the first edge after rst=0.

Configuration
REQ-025 When macro STREAM_DEMUX_CNT_EN is defined, the block SHALL add output ports cnt_a and cnt_b, each 8 bits wide.
REQ-026 With STREAM_DEMUX_CNT_EN defined, cnt_a and cnt_b SHALL count output transfers on port a and port b respectively.
REQ-027 The counters SHALL increment by one per transfer and SHALL wrap from 255 to 0.
REQ-028 Without STREAM_DEMUX_CNT_EN, the ports and counter logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL cover routing: WIDTH=8, both readys=1, send 0x11 with sel=0, then 0x22 with sel=1 -> out_a_data=0x11 one cycle after the first edge, out_b_data=0x22 one cycle after the second, each valid for one cycle.
REQ-030 The bench SHALL cover a stall: out_a_ready=0 with 0x33 held in a, then offer 0x44 with sel=0 -> in_ready=0 and a holds 0x33; raise out_a_ready -> 0x33 transfers and 0x44 is accepted on the same edge (reload).
REQ-031 The bench SHALL cover independence: a FULL and stalled, offer 0x55 with sel=1 -> in_ready=1, and 0x55 appears on b next cycle.
REQ-032 The bench SHALL cover reset mid-operation: both registers FULL and rst=1 for one edge -> both valids=0, both data=0, and the held words are never emitted.
REQ-033 The bench SHALL cover back-to-back streaming: 300 transfers to a with out_a_ready=1 -> throughput of one word per cycle, in order, and with STREAM_DEMUX_CNT_EN defined cnt_a=44 (300 mod 256).
REQ-034 The bench SHALL cover a sel change while stalled: in_valid=1, sel=0 and a blocked, then sel switched to 1 with b EMPTY -> in_ready rises in the same cycle and the word goes to b.
